fir_queue_sequencer: RTL and testbench

- Controller for the 1024x16 dual-port sample queue feeding the low-band FIR.
- Decimates incoming samples and writes them into the RAM at a circular write pointer.
- Once a full tap window is stored, runs one read sweep per accepted sample, oldest to newest, with matching coefficient indices for the MAC datapath.
- Queues at most one pending sweep and flags overruns.

---
 rtl/fir_queue_sequencer.sv | 251 +++++++++++++++++++++++++
 tb/tb_fir_queue_sequencer.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_queue_sequencer.sv
// ---------------------------------------------------------------------------
// fir_queue_sequencer
//
// Purpose:
//   Controller for the dual-port sample queue that feeds the low-band FIR.
//   Incoming samples are decimated and written to the queue RAM at a circular
//   write pointer. Once a full tap window is stored, every accepted sample
//   starts one read sweep over the window, from the oldest sample to the
//   newest, with a matching coefficient index for the MAC datapath. One
//   further sweep can be held pending while a sweep runs; a trigger that
//   finds the pending slot already taken is dropped and flags an overrun.
//
// Ports:
//   i_clk          system clock, all logic on the rising edge
//   i_rst          synchronous active-high reset
//   i_wrt_smpl     single-cycle strobe, i_new_smpl valid
//   i_new_smpl     incoming audio sample (16 bit)
//   i_clr_ovr      clears the sticky overrun flag
//   o_we           RAM write enable
//   o_waddr        RAM write address (current write pointer)
//   o_wdata        RAM write data (registered accepted sample)
//   o_raddr        RAM read address, 0 when no sweep is running
//   o_coeff_addr   coefficient ROM index matching o_raddr, 0 when idle
//   o_rd_vld       o_raddr / o_coeff_addr valid this cycle
//   o_first        first read of a sweep
//   o_last         last read of a sweep
//   o_sequencing   sweep in progress (same as o_rd_vld)
//   o_seq_done     one-cycle pulse in the cycle after o_last
//   o_full         a full window of TAPS samples is stored
//   o_overrun      sticky, a trigger was lost
// ---------------------------------------------------------------------------
module fir_queue_sequencer #(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024,
  parameter int TAPS   = 1021,
  parameter int DECIM  = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_wrt_smpl,
  input  logic [15:0]       i_new_smpl,
  input  logic              i_clr_ovr,
  output logic              o_we,
  output logic [ADDR_W-1:0] o_waddr,
  output logic [15:0]       o_wdata,
  output logic [ADDR_W-1:0] o_raddr,
  output logic [ADDR_W-1:0] o_coeff_addr,
  output logic              o_rd_vld,
  output logic              o_first,
  output logic              o_last,
  output logic              o_sequencing,
  output logic              o_seq_done,
  output logic              o_full,
  output logic              o_overrun
);

  // -------------------------------------------------------------------------
  // Constants
  // -------------------------------------------------------------------------
  localparam int DCNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;

  localparam logic [ADDR_W-1:0] L_TAPS     = ADDR_W'(TAPS);
  localparam logic [ADDR_W-1:0] L_TAPS_M1  = ADDR_W'(TAPS - 1);
  localparam logic [ADDR_W-1:0] L_PTR_MAX  = ADDR_W'(DEPTH - 1);
  localparam logic [DCNT_W-1:0] L_DCNT_MAX = DCNT_W'(DECIM - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SWEEP = 1'b1
  } state_t;

  // Circular increment over the queue depth.
  function automatic logic [ADDR_W-1:0] f_inc(input logic [ADDR_W-1:0] v);
    return (v == L_PTR_MAX) ? '0 : v + ADDR_W'(1);
  endfunction

  // -------------------------------------------------------------------------
  // Input stage: decimation, write strobe, write pointer and fill level
  // -------------------------------------------------------------------------
  logic [DCNT_W-1:0] r_dcnt;
  logic              r_acc;       // high during the write cycle
  logic [15:0]       r_wdata;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_cnt;       // samples stored, saturates at TAPS

  logic w_accept;
  assign w_accept = i_wrt_smpl && (r_dcnt == '0);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_dcnt   <= '0;
      r_acc    <= 1'b0;
      r_wdata  <= '0;
      r_wr_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (i_wrt_smpl) begin
        r_dcnt <= (r_dcnt == L_DCNT_MAX) ? '0 : r_dcnt + DCNT_W'(1);
      end
      r_acc <= w_accept;
      if (w_accept) begin
        r_wdata <= i_new_smpl;
      end
      // The pointer advances at the end of the write cycle, so o_waddr shows
      // the slot being written while o_we is high.
      if (r_acc) begin
        r_wr_ptr <= f_inc(r_wr_ptr);
        if (r_cnt != L_TAPS) begin
          r_cnt <= r_cnt + ADDR_W'(1);
        end
      end
    end
  end

  // A write triggers a sweep when its post-write fill level is TAPS. Since
  // r_cnt never exceeds TAPS, that is a pre-write level of TAPS-1 or TAPS.
  logic              w_trig;
  logic [ADDR_W-1:0] w_start;
  assign w_trig  = r_acc && (r_cnt >= L_TAPS_M1);
  // Oldest sample of the window ending at the slot being written; the
  // subtraction wraps naturally because DEPTH is 2**ADDR_W.
  assign w_start = r_wr_ptr - L_TAPS_M1;

  // -------------------------------------------------------------------------
  // Sweep FSM
  // -------------------------------------------------------------------------
  state_t            r_state;
  logic [ADDR_W-1:0] r_k;          // coefficient index within the sweep
  logic [ADDR_W-1:0] r_raddr;
  logic              r_pend;       // one sweep queued behind the current one
  logic [ADDR_W-1:0] r_pstart;
  logic              r_ovr;
  logic              r_seq_done;

  state_t            w_state_next;
  logic [ADDR_W-1:0] w_k_next;
  logic [ADDR_W-1:0] w_raddr_next;
  logic              w_pend_next;
  logic [ADDR_W-1:0] w_pstart_next;
  logic              w_ovr_set;
  logic              w_ovr_next;
  logic              w_rd_vld;
  logic              w_last;

  assign w_rd_vld = (r_state == S_SWEEP);
  assign w_last   = w_rd_vld && (r_k == L_TAPS_M1);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_k_next      = r_k;
    w_raddr_next  = r_raddr;
    w_pend_next   = r_pend;
    w_pstart_next = r_pstart;
    w_ovr_set     = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_trig) begin
          w_state_next = S_SWEEP;
          w_k_next     = '0;
          w_raddr_next = w_start;
        end
      end

      S_SWEEP: begin
        if (w_last) begin
          if (r_pend) begin
            // Chain the queued sweep with no idle cycle. A trigger arriving
            // now sees the pending slot as free because it is being consumed.
            w_k_next     = '0;
            w_raddr_next = r_pstart;
            w_pend_next  = w_trig;
            if (w_trig) begin
              w_pstart_next = w_start;
            end
          end else if (w_trig) begin
            // Trigger coincident with the last read starts straight away.
            w_k_next     = '0;
            w_raddr_next = w_start;
          end else begin
            w_state_next = S_IDLE;
          end
        end else begin
          w_k_next     = r_k + ADDR_W'(1);
          w_raddr_next = f_inc(r_raddr);
          if (w_trig) begin
            if (!r_pend) begin
              w_pend_next   = 1'b1;
              w_pstart_next = w_start;
            end else begin
              // Keep the older pending window, drop this one.
              w_ovr_set = 1'b1;
            end
          end
        end
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // A new overrun wins over a simultaneous clear.
  assign w_ovr_next = w_ovr_set | (r_ovr & ~i_clr_ovr);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_k        <= '0;
      r_raddr    <= '0;
      r_pend     <= 1'b0;
      r_pstart   <= '0;
      r_ovr      <= 1'b0;
      r_seq_done <= 1'b0;
    end else begin
      r_k        <= w_k_next;
      r_raddr    <= w_raddr_next;
      r_pend     <= w_pend_next;
      r_pstart   <= w_pstart_next;
      r_ovr      <= w_ovr_next;
      r_seq_done <= w_last;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign o_we         = r_acc;
  assign o_waddr      = r_wr_ptr;
  assign o_wdata      = r_wdata;
  // Read-side indices are forced to 0 outside a sweep so idle and reset
  // look identical to the MAC datapath.
  assign o_raddr      = w_rd_vld ? r_raddr : '0;
  assign o_coeff_addr = w_rd_vld ? r_k : '0;
  assign o_rd_vld     = w_rd_vld;
  assign o_first      = w_rd_vld && (r_k == '0);
  assign o_last       = w_last;
  assign o_sequencing = w_rd_vld;
  assign o_seq_done   = r_seq_done;
  assign o_full       = (r_cnt == L_TAPS);
  assign o_overrun    = r_ovr;

endmodule

// File: tb/tb_fir_queue_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fir_queue_sequencer
//
// Two instances: unit 0 with the production configuration (1024/1021/2) and
// unit 1 with a small one (8/5/1) for back-to-back and overrun cases.
// A timeline model predicts every output each cycle; directed checks pin
// specific values computed by hand.
// ---------------------------------------------------------------------------
module tb_fir_queue_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst  [2];
  logic        wrt  [2];
  logic        clr  [2];
  logic [15:0] smp  [2];

  int checks = 0;
  int errors = 0;
  bit armed  = 1'b0;

  // ----------------------------------------------------------------- DUTs
  logic       u0_we, u0_rd_vld, u0_first, u0_last, u0_seq, u0_done, u0_full, u0_ovr;
  logic [9:0] u0_waddr, u0_raddr, u0_coeff;
  logic [15:0] u0_wdata;
  logic       u1_we, u1_rd_vld, u1_first, u1_last, u1_seq, u1_done, u1_full, u1_ovr;
  logic [2:0] u1_waddr, u1_raddr, u1_coeff;
  logic [15:0] u1_wdata;

  fir_queue_sequencer #(.ADDR_W(10), .DEPTH(1024), .TAPS(1021), .DECIM(2)) u_dut0 (
    .i_clk(clk), .i_rst(rst[0]), .i_wrt_smpl(wrt[0]), .i_new_smpl(smp[0]),
    .i_clr_ovr(clr[0]), .o_we(u0_we), .o_waddr(u0_waddr), .o_wdata(u0_wdata),
    .o_raddr(u0_raddr), .o_coeff_addr(u0_coeff), .o_rd_vld(u0_rd_vld),
    .o_first(u0_first), .o_last(u0_last), .o_sequencing(u0_seq),
    .o_seq_done(u0_done), .o_full(u0_full), .o_overrun(u0_ovr));

  fir_queue_sequencer #(.ADDR_W(3), .DEPTH(8), .TAPS(5), .DECIM(1)) u_dut1 (
    .i_clk(clk), .i_rst(rst[1]), .i_wrt_smpl(wrt[1]), .i_new_smpl(smp[1]),
    .i_clr_ovr(clr[1]), .o_we(u1_we), .o_waddr(u1_waddr), .o_wdata(u1_wdata),
    .o_raddr(u1_raddr), .o_coeff_addr(u1_coeff), .o_rd_vld(u1_rd_vld),
    .o_first(u1_first), .o_last(u1_last), .o_sequencing(u1_seq),
    .o_seq_done(u1_done), .o_full(u1_full), .o_overrun(u1_ovr));

  // Per-unit observation, widened to 10-bit addresses.
  logic        ob_we [2], ob_rv [2], ob_first [2], ob_last [2], ob_seq [2];
  logic        ob_done [2], ob_full [2], ob_ovr [2];
  logic [9:0]  ob_waddr [2], ob_raddr [2], ob_coeff [2];
  logic [15:0] ob_wdata [2];

  always_comb begin
    ob_we[0] = u0_we;  ob_waddr[0] = u0_waddr;  ob_wdata[0] = u0_wdata;
    ob_raddr[0] = u0_raddr;  ob_coeff[0] = u0_coeff;  ob_rv[0] = u0_rd_vld;
    ob_first[0] = u0_first;  ob_last[0] = u0_last;  ob_seq[0] = u0_seq;
    ob_done[0] = u0_done;  ob_full[0] = u0_full;  ob_ovr[0] = u0_ovr;
    ob_we[1] = u1_we;  ob_waddr[1] = {7'd0, u1_waddr};  ob_wdata[1] = u1_wdata;
    ob_raddr[1] = {7'd0, u1_raddr};  ob_coeff[1] = {7'd0, u1_coeff};  ob_rv[1] = u1_rd_vld;
    ob_first[1] = u1_first;  ob_last[1] = u1_last;  ob_seq[1] = u1_seq;
    ob_done[1] = u1_done;  ob_full[1] = u1_full;  ob_ovr[1] = u1_ovr;
  end

  function automatic logic [53:0] pk(logic we, logic [9:0] wa, logic [15:0] wd,
                                     logic [9:0] ra, logic [9:0] ca, logic rv,
                                     logic fi, logic la, logic sq, logic dn,
                                     logic fu, logic ov);
    return {we, wa, wd, ra, ca, rv, fi, la, sq, dn, fu, ov};
  endfunction

  function automatic int taps(int u);  return (u == 0) ? 1021 : 5;  endfunction
  function automatic int depth(int u); return (u == 0) ? 1024 : 8;  endfunction
  function automatic int decim(int u); return (u == 0) ? 2 : 1;     endfunction
  function automatic logic [15:0] sval(int i); return 16'(i * 37 + 11); endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------- model
  // Timeline view: a write at cycle n requests a sweep over cycles n+1..;
  // a running sweep occupies [cs, cs+TAPS), one request may wait behind it.
  longint      cyc = 0;
  int          m_dcnt [2], m_wptr [2], m_cnt [2], m_ca [2], m_pa [2];
  bit          m_wpend [2], m_cur_v [2], m_pv [2], m_ovr [2];
  longint      m_cs [2];
  logic [15:0] m_wd [2];
  logic [53:0] exp_v [2];

  always @(posedge clk) begin
    cyc++;
    for (int u = 0; u < 2; u++) begin
      bit trig, newovr, done, acc;
      int ts, k, ra;
      if (rst[u]) begin
        m_dcnt[u] = 0; m_wptr[u] = 0; m_cnt[u] = 0; m_wpend[u] = 0;
        m_cur_v[u] = 0; m_pv[u] = 0; m_pa[u] = 0; m_ovr[u] = 0;
        m_wd[u] = '0; m_cs[u] = 0; m_ca[u] = 0;
        exp_v[u] = '0;
      end else begin
        trig = 0; ts = 0; newovr = 0; done = 0; acc = 0;
        if (m_wpend[u]) begin
          ts = ((m_wptr[u] - (taps(u) - 1)) % depth(u) + depth(u)) % depth(u);
          m_wptr[u] = (m_wptr[u] + 1) % depth(u);
          if (m_cnt[u] < taps(u)) m_cnt[u]++;
          trig = (m_cnt[u] == taps(u));
        end
        if (m_cur_v[u] && cyc == m_cs[u] + taps(u)) begin
          done = 1;
          m_cur_v[u] = 0;
          if (m_pv[u]) begin
            m_cur_v[u] = 1; m_cs[u] = cyc; m_ca[u] = m_pa[u]; m_pv[u] = 0;
          end
        end
        if (trig) begin
          if (!m_cur_v[u]) begin
            m_cur_v[u] = 1; m_cs[u] = cyc; m_ca[u] = ts;
          end else if (!m_pv[u]) begin
            m_pv[u] = 1; m_pa[u] = ts;
          end else begin
            newovr = 1;
          end
        end
        m_ovr[u] = (m_ovr[u] && !clr[u]) || newovr;
        if (wrt[u]) begin
          if (m_dcnt[u] == 0) begin
            acc = 1; m_wd[u] = smp[u];
          end
          m_dcnt[u] = (m_dcnt[u] + 1) % decim(u);
        end
        m_wpend[u] = acc;
        k  = m_cur_v[u] ? int'(cyc - m_cs[u]) : 0;
        ra = m_cur_v[u] ? (m_ca[u] + k) % depth(u) : 0;
        exp_v[u] = pk(acc, 10'(m_wptr[u]), m_wd[u], 10'(ra), 10'(k), m_cur_v[u],
                      m_cur_v[u] && k == 0, m_cur_v[u] && k == taps(u) - 1,
                      m_cur_v[u], done, m_cnt[u] == taps(u), m_ovr[u]);
      end
    end
  end

  // ------------------------------------------------- compare and monitor
  int mon_start [2], mon_len [2], mon_lastaddr [2], mon_lastlen [2], mon_lastcoeff [2];
  int mon_sweeps [2], mon_b2b [2], mon_writes [2], mon_waddr [2], mon_done [2], mon_rvcyc [2];
  logic [15:0] mon_wdata [2];
  bit prev_last [2];
  int sw_log [2][64];

  initial begin
    for (int u = 0; u < 2; u++) begin
      mon_start[u] = 0; mon_len[u] = 0; mon_lastaddr[u] = 0; mon_lastlen[u] = 0;
      mon_lastcoeff[u] = 0; mon_sweeps[u] = 0; mon_b2b[u] = 0; mon_writes[u] = 0;
      mon_waddr[u] = 0; mon_done[u] = 0; mon_rvcyc[u] = 0; mon_wdata[u] = '0;
      prev_last[u] = 0;
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      for (int u = 0; u < 2; u++) begin
        logic [53:0] ob;
        ob = pk(ob_we[u], ob_waddr[u], ob_wdata[u], ob_raddr[u], ob_coeff[u], ob_rv[u],
                ob_first[u], ob_last[u], ob_seq[u], ob_done[u], ob_full[u], ob_ovr[u]);
        checks++;
        if (ob !== exp_v[u]) begin
          errors++;
          $display("FAIL cycle_u%0d t=%0t: got %h expected %h", u, $time, ob, exp_v[u]);
        end
        if (ob_rv[u]) begin
          mon_rvcyc[u]++;
          if (ob_first[u]) begin
            mon_start[u] = int'(ob_raddr[u]);
            mon_len[u] = 1;
            if (prev_last[u]) mon_b2b[u]++;
          end else begin
            mon_len[u]++;
          end
          if (ob_last[u]) begin
            mon_lastaddr[u] = int'(ob_raddr[u]);
            mon_lastcoeff[u] = int'(ob_coeff[u]);
            mon_lastlen[u] = mon_len[u];
            sw_log[u][mon_sweeps[u] % 64] = mon_start[u];
            mon_sweeps[u]++;
            $display("unit %0d sweep %0d: start %0d end %0d reads %0d", u, mon_sweeps[u],
                     mon_start[u], mon_lastaddr[u], mon_len[u]);
          end
        end
        if (ob_we[u]) begin
          mon_writes[u]++;
          mon_waddr[u] = int'(ob_waddr[u]);
          mon_wdata[u] = ob_wdata[u];
        end
        if (ob_done[u]) mon_done[u]++;
        prev_last[u] = ob_rv[u] && ob_last[u];
      end
    end
  end

  // ------------------------------------------------------------ stimulus
  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic strobe(int u, logic [15:0] v);
    wrt[u] = 1'b1;
    smp[u] = v;
    tick(1);
    wrt[u] = 1'b0;
  endtask

  task automatic wait_sweep(int u, int budget, string nm);
    int base;
    int n;
    base = mon_sweeps[u];
    n = 0;
    while (mon_sweeps[u] == base && n < budget) begin
      tick(1);
      n++;
    end
    chk(nm, 32'(mon_sweeps[u] - base), 32'd1);
  endtask

  int s0 = 0;

  initial begin
    int base, n;
    for (int u = 0; u < 2; u++) begin
      rst[u] = 1'b1; wrt[u] = 1'b0; clr[u] = 1'b0; smp[u] = '0;
    end
    tick(1);
    armed = 1'b1;
    tick(1);
    rst[0] = 1'b0;
    rst[1] = 1'b0;

    // Reset state
    chk("rst_we", 32'(u0_we), 0);
    chk("rst_waddr", 32'(u0_waddr), 0);
    chk("rst_rd_vld", 32'(u0_rd_vld), 0);
    chk("rst_full", 32'(u0_full), 0);
    chk("rst_overrun", 32'(u0_ovr), 0);

    // 1: 2040 strobes, 4 clk apart -> 1020 writes, no sweep
    for (int i = 0; i < 2040; i++) begin
      strobe(0, sval(s0)); s0++;
      tick(3);
    end
    chk("fill_writes", 32'(mon_writes[0]), 1020);
    chk("fill_last_waddr", 32'(mon_waddr[0]), 1019);
    chk("fill_last_wdata", 32'(mon_wdata[0]), 32'(sval(2038)));
    chk("fill_full", 32'(u0_full), 0);
    chk("fill_no_read", 32'(mon_rvcyc[0]), 0);

    // 2: the 1021st write triggers the first sweep
    strobe(0, sval(s0)); s0++;
    chk("trig_we", 32'(u0_we), 1);
    chk("trig_waddr", 32'(u0_waddr), 1020);
    tick(1);
    chk("sweep0_rd_vld", 32'(u0_rd_vld), 1);
    chk("sweep0_first", 32'(u0_first), 1);
    chk("sweep0_raddr0", 32'(u0_raddr), 0);
    chk("sweep0_full", 32'(u0_full), 1);
    strobe(0, sval(s0)); s0++;
    wait_sweep(0, 1100, "sweep0_timeout");
    chk("sweep0_len", 32'(mon_lastlen[0]), 1021);
    chk("sweep0_end_raddr", 32'(mon_lastaddr[0]), 1020);
    chk("sweep0_end_coeff", 32'(mon_lastcoeff[0]), 1020);
    chk("sweep0_seq_done", 32'(u0_done), 1);
    tick(1);
    chk("sweep0_done_pulse", 32'(u0_done), 0);

    // 3: pointer wrap, one sweep per write
    for (int j = 0; j < 7; j++) begin
      strobe(0, sval(s0)); s0++;
      chk("wrap_waddr", 32'(u0_waddr), 32'((1021 + j) % 1024));
      strobe(0, sval(s0)); s0++;
      wait_sweep(0, 1100, "wrap_timeout");
    end
    chk("wrap_start", 32'(mon_start[0]), 7);
    chk("wrap_end", 32'(mon_lastaddr[0]), 3);
    chk("wrap_len", 32'(mon_lastlen[0]), 1021);

    // 5: reset in the middle of a sweep
    strobe(0, sval(s0)); s0++;
    strobe(0, sval(s0)); s0++;
    n = 0;
    while (!(u0_rd_vld && u0_coeff == 10'd500) && n < 700) begin
      tick(1);
      n++;
    end
    chk("mid_k500", 32'(u0_coeff), 500);
    rst[0] = 1'b1;
    tick(1);
    rst[0] = 1'b0;
    chk("mid_rst_outputs", 32'(pk(u0_we, u0_waddr, u0_wdata, u0_raddr, u0_coeff, u0_rd_vld,
        u0_first, u0_last, u0_seq, u0_done, u0_full, u0_ovr) != 54'd0), 0);
    base = mon_done[0];
    tick(4);
    chk("mid_no_seq_done", 32'(mon_done[0] - base), 0);
    base = mon_rvcyc[0];
    n = mon_writes[0];
    for (int i = 0; i < 2040; i++) begin
      strobe(0, sval(i + 5000));
      tick(1);
    end
    chk("refill_writes", 32'(mon_writes[0] - n), 1020);
    chk("refill_no_read", 32'(mon_rvcyc[0] - base), 0);
    chk("refill_not_full", 32'(u0_full), 0);
    strobe(0, 16'hBEEF);
    tick(1);
    chk("refill_sweep_vld", 32'(u0_rd_vld), 1);
    chk("refill_sweep_raddr", 32'(u0_raddr), 0);
    wait_sweep(0, 1100, "refill_timeout");

    // 4: small config, strobes every cycle -> back-to-back, pending, overrun
    base = mon_b2b[1];
    wrt[1] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      smp[1] = sval(i + 100);
      tick(1);
    end
    wrt[1] = 1'b0;
    tick(25);
    chk("small_sweeps", 32'(mon_sweeps[1]), 3);
    chk("small_start0", 32'(sw_log[1][0]), 0);
    chk("small_start1", 32'(sw_log[1][1]), 1);
    chk("small_start2", 32'(sw_log[1][2]), 5);
    chk("small_end2", 32'(mon_lastaddr[1]), 1);
    chk("small_b2b", 32'(mon_b2b[1] - base), 2);
    chk("small_overrun", 32'(u1_ovr), 1);
    clr[1] = 1'b1;
    tick(1);
    clr[1] = 1'b0;
    chk("small_clr_ovr", 32'(u1_ovr), 0);

    // 6: trigger in the same cycle as last
    base = mon_b2b[1];
    strobe(1, 16'h1234);
    tick(4);
    strobe(1, 16'h5678);
    tick(15);
    chk("coinc_sweeps", 32'(mon_sweeps[1]), 5);
    chk("coinc_start_a", 32'(sw_log[1][3]), 6);
    chk("coinc_start_b", 32'(sw_log[1][4]), 7);
    chk("coinc_end_b", 32'(mon_lastaddr[1]), 3);
    chk("coinc_b2b", 32'(mon_b2b[1] - base), 1);
    chk("coinc_overrun", 32'(u1_ovr), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
